// File: rtl/hht_pkg.sv
// Shared types and sizing for the HHT read/compute controller.
package hht_pkg;

    localparam int DW    = 32;
    localparam int V_LEN = 16;
    localparam int IW    = $clog2(V_LEN);

    typedef enum logic [2:0] {
        IDLE,
        LOAD_V,
        DOT,
        EMIT,
        DONE
    } state_e;

endpackage

// File: rtl/hht_mac.sv
// Multiply-accumulate unit: unsigned product truncated to DW bits, wrapping accumulator.
module hht_mac
    import hht_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_i,
    input  logic          en_i,
    input  logic [DW-1:0] a_i,
    input  logic [DW-1:0] b_i,
    output logic [DW-1:0] sum_o
);

    logic [DW-1:0] acc_q;
    logic [DW-1:0] acc_d;
    logic [DW-1:0] prod;

    assign prod  = a_i * b_i;
    // sum_o exposes the accumulation including the current product so the
    // controller can capture the final column result on the last DOT cycle.
    assign sum_o = acc_q + prod;

    always_comb begin
        acc_d = acc_q;
        if (clr_i) begin
            acc_d = '0;
        end else if (en_i) begin
            acc_d = sum_o;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc_q <= '0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/hht_control.sv
// HHT controller: loads vector v from port 2, then emits one dot product per
// V_LEN-word column streamed from port 1.
module hht_control
    import hht_pkg::*;
(
    input  logic          Clk,
    input  logic          Rst,
    input  logic [DW-1:0] v_values_base,
    input  logic [DW-1:0] wdata_col_base,
    output logic [DW-1:0] addr1,
    output logic [DW-1:0] addr2,
    input  logic [DW-1:0] dataIn1,
    input  logic [DW-1:0] dataIn2,
    input  logic [DW-1:0] csize,
    input  logic          RD,
    output logic [DW-1:0] dot_out,
    output logic          dot_valid,
    output logic          done
);

    state_e        state_q;
    logic [DW-1:0] addr1_q;
    logic [DW-1:0] addr2_q;
    logic [DW-1:0] csize_q;
    logic [DW-1:0] total_q;
    logic [IW-1:0] idx_q;
    logic [DW-1:0] v_q [V_LEN];
    logic [DW-1:0] dot_out_q;
    logic          dot_valid_q;
    logic          done_q;

    logic          last_word;
    logic          col_end;
    logic          mac_clr;
    logic          mac_en;
    logic [DW-1:0] mac_sum;

    assign last_word = (total_q == csize_q - DW'(1));
    assign col_end   = last_word || (idx_q == IW'(V_LEN - 1));
    assign mac_en    = (state_q == DOT);
    assign mac_clr   = (state_q != DOT);

    hht_mac u_mac (
        .clk   (Clk),
        .rst   (Rst),
        .clr_i (mac_clr),
        .en_i  (mac_en),
        .a_i   (v_q[idx_q]),
        .b_i   (dataIn1),
        .sum_o (mac_sum)
    );

    always_ff @(posedge Clk or posedge Rst) begin
        if (Rst) begin
            state_q     <= IDLE;
            addr1_q     <= '0;
            addr2_q     <= '0;
            csize_q     <= '0;
            total_q     <= '0;
            idx_q       <= '0;
            dot_out_q   <= '0;
            dot_valid_q <= 1'b0;
            done_q      <= 1'b0;
            for (int k = 0; k < V_LEN; k++) begin
                v_q[k] <= '0;
            end
        end else begin
            dot_valid_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (RD) begin
                        addr1_q <= wdata_col_base;
                        addr2_q <= v_values_base;
                        csize_q <= csize;
                        total_q <= '0;
                        idx_q   <= '0;
                        if (csize == '0) begin
                            state_q <= DONE;
                            done_q  <= 1'b1;
                        end else begin
                            state_q <= LOAD_V;
                        end
                    end
                end
                LOAD_V: begin
                    v_q[idx_q] <= dataIn2;
                    addr2_q    <= addr2_q + DW'(1);
                    if (idx_q == IW'(V_LEN - 1)) begin
                        idx_q   <= '0;
                        state_q <= DOT;
                    end else begin
                        idx_q <= idx_q + IW'(1);
                    end
                end
                DOT: begin
                    idx_q   <= idx_q + IW'(1);
                    total_q <= total_q + DW'(1);
                    // The address stops on the final word so it never runs past the data.
                    if (!last_word) begin
                        addr1_q <= addr1_q + DW'(1);
                    end
                    if (col_end) begin
                        dot_out_q   <= mac_sum;
                        dot_valid_q <= 1'b1;
                        state_q     <= EMIT;
                    end
                end
                EMIT: begin
                    idx_q <= '0;
                    if (total_q < csize_q) begin
                        state_q <= DOT;
                    end else begin
                        state_q <= DONE;
                        done_q  <= 1'b1;
                    end
                end
                DONE: begin
                    if (!RD) begin
                        state_q <= IDLE;
                        done_q  <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign addr1     = addr1_q;
    assign addr2     = addr2_q;
    assign dot_out   = dot_out_q;
    assign dot_valid = dot_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_hht_control.sv
// Directed self-checking bench for hht_control with behavioural zero-latency memories.
module tb_hht_control;

    logic        Clk = 1'b0;
    logic        Rst;
    logic [31:0] v_values_base;
    logic [31:0] wdata_col_base;
    logic [31:0] addr1;
    logic [31:0] addr2;
    logic [31:0] dataIn1;
    logic [31:0] dataIn2;
    logic [31:0] csize;
    logic        RD;
    logic [31:0] dot_out;
    logic        dot_valid;
    logic        done;

    logic [31:0] mem1 [0:511];
    logic [31:0] mem2 [0:63];

    logic [31:0] pulses [$];
    logic [31:0] saved [10];
    logic [31:0] addr2Trace [16];
    logic [31:0] addr1Max;
    int          checks = 0;
    int          errors = 0;
    int          cyc;

    always #5 Clk = ~Clk;

    assign dataIn1 = mem1[addr1[8:0]];
    assign dataIn2 = mem2[addr2[5:0]];

    hht_control dut (
        .Clk            (Clk),
        .Rst            (Rst),
        .v_values_base  (v_values_base),
        .wdata_col_base (wdata_col_base),
        .addr1          (addr1),
        .addr2          (addr2),
        .dataIn1        (dataIn1),
        .dataIn2        (dataIn2),
        .csize          (csize),
        .RD             (RD),
        .dot_out        (dot_out),
        .dot_valid      (dot_valid),
        .done           (done)
    );

    // Record every result strobe.
    always @(negedge Clk) begin
        if (dot_valid === 1'b1) pulses.push_back(dot_out);
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected)
        else begin
            errors++;
            $error("[TB] FAIL %s: observed=%0d (0x%08h) expected=%0d (0x%08h)", tag, observed, observed, expected, expected);
        end
    endtask

    function automatic logic [31:0] pulseAt(input int i);
        if (i < pulses.size()) return pulses[i];
        return 32'hxxxx_xxxx;
    endfunction

    function automatic logic [31:0] dotModel(input int vb, input int cb, input int len);
        logic [31:0] s;
        s = '0;
        for (int k = 0; k < len; k++) s = s + mem2[vb + k] * mem1[cb + k];
        return s;
    endfunction

    // Start a run and wait (bounded) for done; base/csize are scrambled after the start cycle.
    task automatic applyStimulus(input logic [31:0] vb, input logic [31:0] cb, input logic [31:0] cs,
                                 input int budget, output int cycles);
        pulses.delete();
        addr1Max       = '0;
        v_values_base  = vb;
        wdata_col_base = cb;
        csize          = cs;
        RD             = 1'b1;
        cycles         = 0;
        do begin
            @(negedge Clk);
            cycles++;
            if (cycles == 1) begin
                v_values_base  = 32'd40;
                wdata_col_base = 32'd7;
                csize          = 32'd3;
            end
            if (cycles <= 16) addr2Trace[cycles-1] = addr2;
            if (addr1 > addr1Max) addr1Max = addr1;
        end while (done !== 1'b1 && cycles < budget);
        checkOutput("done reached", {31'd0, done}, 32'd1);
    endtask

    initial begin
        Rst = 1'b1; RD = 1'b0;
        v_values_base = '0; wdata_col_base = '0; csize = '0;
        for (int a = 0; a < 512; a++) mem1[a] = '0;
        for (int a = 0; a < 64; a++) mem2[a] = '0;
        begin
            logic [31:0] vInit [16] = '{84,8,66,52,57,5,44,2,34,55,31,60,17,35,18,30};
            logic [31:0] cFirst [16] = '{7,12,6,11,8,7,1,4,1,0,15,8,4,9,2,0};
            logic [31:0] cLast [10] = '{13,3,1,11,1,12,4,3,12,14};
            for (int a = 180; a <= 333; a++) mem1[a] = 32'(a % 13);
            for (int k = 0; k < 16; k++) mem2[2 + k] = vInit[k];
            for (int k = 0; k < 16; k++) mem1[180 + k] = cFirst[k];
            for (int k = 0; k < 10; k++) mem1[324 + k] = cLast[k];
            for (int k = 0; k < 16; k++) mem2[32 + k] = 32'hFFFF_FFFF;
            for (int k = 0; k < 16; k++) mem1[400 + k] = 32'(k + 1);
        end

        // Reset state
        repeat (2) @(negedge Clk);
        checkOutput("reset addr1", addr1, 32'd0);
        checkOutput("reset addr2", addr2, 32'd0);
        checkOutput("reset dot_out", dot_out, 32'd0);
        checkOutput("reset dot_valid", {31'd0, dot_valid}, 32'd0);
        checkOutput("reset done", {31'd0, done}, 32'd0);
        Rst = 1'b0;
        @(negedge Clk);

        // Single full column
        applyStimulus(32'd2, 32'd180, 32'd16, 200, cyc);
        checkOutput("full cycles", 32'(cyc), 32'd34);
        checkOutput("full pulse count", 32'(pulses.size()), 32'd1);
        checkOutput("full dot_out", pulseAt(0), 32'd3593);
        for (int i = 0; i < 16; i++) checkOutput("addr2 walk", addr2Trace[i], 32'(2 + i));
        checkOutput("full addr1 final", addr1, 32'd195);
        checkOutput("full addr1 max", addr1Max, 32'd195);

        // Holding RD keeps done; dropping it returns to idle
        repeat (5) @(negedge Clk);
        checkOutput("hold done", {31'd0, done}, 32'd1);
        checkOutput("hold no new pulse", 32'(pulses.size()), 32'd1);
        RD = 1'b0;
        @(negedge Clk);
        checkOutput("drop RD clears done", {31'd0, done}, 32'd0);

        // Partial tail column
        applyStimulus(32'd2, 32'd180, 32'd154, 400, cyc);
        checkOutput("tail cycles", 32'(cyc), 32'd181);
        checkOutput("tail pulse count", 32'(pulses.size()), 32'd10);
        checkOutput("tail first", pulseAt(0), 32'd3593);
        checkOutput("tail last", pulseAt(9), 32'd3231);
        for (int c = 0; c < 10; c++) begin
            int len;
            len = (154 - 16 * c < 16) ? 154 - 16 * c : 16;
            checkOutput("tail column", pulseAt(c), dotModel(2, 180 + 16 * c, len));
            saved[c] = pulseAt(c);
        end
        checkOutput("tail addr1 max", addr1Max, 32'd333);
        checkOutput("tail addr1 final", addr1, 32'd333);
        RD = 1'b0;
        @(negedge Clk);

        // Identical rerun
        applyStimulus(32'd2, 32'd180, 32'd154, 400, cyc);
        checkOutput("rerun pulse count", 32'(pulses.size()), 32'd10);
        for (int c = 0; c < 10; c++) checkOutput("rerun column", pulseAt(c), saved[c]);
        RD = 1'b0;
        @(negedge Clk);

        // csize = 0
        applyStimulus(32'd2, 32'd180, 32'd0, 50, cyc);
        checkOutput("zero cycles", 32'(cyc), 32'd1);
        repeat (3) @(negedge Clk);
        checkOutput("zero no pulse", 32'(pulses.size()), 32'd0);
        RD = 1'b0;
        @(negedge Clk);

        // Wrapping products: sum of -k for k=1..16 = -136
        applyStimulus(32'd32, 32'd400, 32'd16, 200, cyc);
        checkOutput("wrap pulse count", 32'(pulses.size()), 32'd1);
        checkOutput("wrap dot_out", pulseAt(0), 32'hFFFF_FF78);
        RD = 1'b0;
        @(negedge Clk);

        // Reset in the middle of DOT
        v_values_base = 32'd2; wdata_col_base = 32'd180; csize = 32'd154; RD = 1'b1;
        repeat (25) @(negedge Clk);
        Rst = 1'b1; RD = 1'b0;
        #1;
        checkOutput("midrst addr1", addr1, 32'd0);
        checkOutput("midrst addr2", addr2, 32'd0);
        checkOutput("midrst done", {31'd0, done}, 32'd0);
        checkOutput("midrst dot_valid", {31'd0, dot_valid}, 32'd0);
        repeat (2) @(negedge Clk);
        Rst = 1'b0;
        pulses.delete();
        repeat (40) @(negedge Clk);
        checkOutput("midrst no pulse", 32'(pulses.size()), 32'd0);
        checkOutput("midrst idle done", {31'd0, done}, 32'd0);

        // Recovery after reset
        applyStimulus(32'd2, 32'd180, 32'd16, 200, cyc);
        checkOutput("recover dot_out", pulseAt(0), 32'd3593);
        RD = 1'b0;
        @(negedge Clk);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
